distram_read_bypass_stage: RTL and testbench

- Pipeline stage sitting directly downstream of a 2-read/1-write distributed-RAM register array.
- Drives both read indices and captures both read data words into an output register with valid/ready handshake.
- Forwards same-cycle writes, which the array only commits at the next edge, so every delivered word is never stale.
- Snoops writes while an entry is held, so stalled entries are never stale either.

---
 rtl/distram_pkg.sv | 50 +++++
 rtl/distram_read_bypass_entry.sv | 45 ++++
 rtl/distram_read_bypass_stage.sv | 135 +++++++++++++
 tb/tb_distram_read_bypass_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/distram_pkg.sv
// Types and helpers shared by the distributed-RAM read bypass stage and its held entries.
// Widths here must match the parameters the stage is instantiated with.
package distram_pkg;

  localparam int PKG_INNER_WIDTH = 32;
  localparam int PKG_OUTER_WIDTH = 32;
  localparam int PKG_TAG_WIDTH   = 8;
  localparam int IDX_WIDTH       = $clog2(PKG_OUTER_WIDTH);

  typedef struct packed {
    logic [IDX_WIDTH-1:0]       index0;
    logic [IDX_WIDTH-1:0]       index1;
    logic [PKG_INNER_WIDTH-1:0] data0;
    logic [PKG_INNER_WIDTH-1:0] data1;
    logic [PKG_TAG_WIDTH-1:0]   tag;
  } rd_entry_t;

  function automatic logic idx_hit(
    input logic                 wen,
    input logic [IDX_WIDTH-1:0] windex,
    input logic [IDX_WIDTH-1:0] index
  );
    return wen && (windex == index);
  endfunction

  // The array commits a write only at the next edge, so a matching write wins over read data.
  function automatic logic [PKG_INNER_WIDTH-1:0] bypass_sel(
    input logic                       wen,
    input logic [IDX_WIDTH-1:0]       windex,
    input logic [IDX_WIDTH-1:0]       index,
    input logic [PKG_INNER_WIDTH-1:0] wdata,
    input logic [PKG_INNER_WIDTH-1:0] rdata
  );
    return idx_hit(wen, windex, index) ? wdata : rdata;
  endfunction

  function automatic rd_entry_t snoop_entry(
    input rd_entry_t                  e,
    input logic                       wen,
    input logic [IDX_WIDTH-1:0]       windex,
    input logic [PKG_INNER_WIDTH-1:0] wdata
  );
    rd_entry_t r;
    r       = e;
    r.data0 = bypass_sel(wen, windex, e.index0, wdata, e.data0);
    r.data1 = bypass_sel(wen, windex, e.index1, wdata, e.data1);
    return r;
  endfunction

endpackage

// File: rtl/distram_read_bypass_entry.sv
// One held read result: loads a captured entry, and while valid replaces the data of any
// lane whose index is being written this cycle (hit flags come from the owner).
module distram_read_bypass_entry
  import distram_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_load,
  input  rd_entry_t                  i_entry,
  input  logic                       i_clear,
  input  logic                       i_hit0,
  input  logic                       i_hit1,
  input  logic [PKG_INNER_WIDTH-1:0] i_wdata,
  output logic                       o_valid,
  output rd_entry_t                  o_entry
);

  logic      r_valid;
  rd_entry_t r_entry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end
      // Snoop runs even on the popping edge; the entry is gone afterwards so it is harmless.
      if (r_valid && i_hit0) begin
        r_entry.data0 <= i_wdata;
      end
      if (r_valid && i_hit1) begin
        r_entry.data1 <= i_wdata;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/distram_read_bypass_stage.sv
// Read stage behind a 2R/1W distributed-RAM array: drives read indices, captures both words
// with same-cycle write forwarding, and snoops writes into held results.
// Optional 2-entry skid buffer (registered in_ready) under DISTRAM_READ_BYPASS_SKID_EN.
module distram_read_bypass_stage
  import distram_pkg::*;
#(
  parameter int INNER_WIDTH = PKG_INNER_WIDTH,
  parameter int OUTER_WIDTH = PKG_OUTER_WIDTH,
  parameter int TAG_WIDTH   = PKG_TAG_WIDTH
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(OUTER_WIDTH)-1:0] in_index0,
  input  logic [$clog2(OUTER_WIDTH)-1:0] in_index1,
  input  logic [TAG_WIDTH-1:0]           in_tag,
  output logic [$clog2(OUTER_WIDTH)-1:0] port0_rindex,
  input  logic [INNER_WIDTH-1:0]         port0_rdata,
  output logic [$clog2(OUTER_WIDTH)-1:0] port1_rindex,
  input  logic [INNER_WIDTH-1:0]         port1_rdata,
  input  logic                           wen,
  input  logic [$clog2(OUTER_WIDTH)-1:0] windex,
  input  logic [INNER_WIDTH-1:0]         wdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INNER_WIDTH-1:0]         out_data0,
  output logic [INNER_WIDTH-1:0]         out_data1,
  output logic [TAG_WIDTH-1:0]           out_tag
);

  // Valid/ready: a transfer happens on an edge where valid and ready are both 1; the source
  // keeps valid and payload stable until that edge, and ready never depends on valid.
  logic      w_push;
  logic      w_pop;
  rd_entry_t w_capture;
  rd_entry_t w_head_src;
  rd_entry_t w_head_entry;
  logic      w_head_valid;
  logic      w_head_load;
  logic      w_head_clear;
  logic      w_head_hit0;
  logic      w_head_hit1;

  assign port0_rindex = in_index0;
  assign port1_rindex = in_index1;

  always_comb begin
    w_capture        = '0;
    w_capture.index0 = in_index0;
    w_capture.index1 = in_index1;
    w_capture.data0  = bypass_sel(wen, windex, in_index0, wdata, port0_rdata);
    w_capture.data1  = bypass_sel(wen, windex, in_index1, wdata, port1_rdata);
    w_capture.tag    = in_tag;
  end

  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_head_valid && out_ready;
  assign w_head_hit0 = idx_hit(wen, windex, w_head_entry.index0);
  assign w_head_hit1 = idx_hit(wen, windex, w_head_entry.index1);

`ifdef DISTRAM_READ_BYPASS_SKID_EN
  logic      w_skid_valid;
  rd_entry_t w_skid_entry;
  logic      w_skid_load;
  logic      w_skid_clear;
  logic      w_skid_hit0;
  logic      w_skid_hit1;

  // Skid occupancy is a flop, so in_ready has no path from out_ready.
  assign in_ready    = !w_skid_valid;
  assign w_skid_hit0 = idx_hit(wen, windex, w_skid_entry.index0);
  assign w_skid_hit1 = idx_hit(wen, windex, w_skid_entry.index1);

  always_comb begin
    w_head_load  = 1'b0;
    w_head_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    w_head_src   = w_capture;
    if (w_pop && w_skid_valid) begin
      // Skid advances with this cycle's write applied; no push is possible while it is full.
      w_head_load  = 1'b1;
      w_head_src   = snoop_entry(w_skid_entry, wen, windex, wdata);
      w_skid_clear = 1'b1;
    end else if (w_push && (!w_head_valid || w_pop)) begin
      w_head_load = 1'b1;
    end else if (w_push) begin
      w_skid_load = 1'b1;
    end else if (w_pop) begin
      w_head_clear = 1'b1;
    end
  end

  distram_read_bypass_entry u_skid (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_load  (w_skid_load),
    .i_entry (w_capture),
    .i_clear (w_skid_clear),
    .i_hit0  (w_skid_hit0),
    .i_hit1  (w_skid_hit1),
    .i_wdata (wdata),
    .o_valid (w_skid_valid),
    .o_entry (w_skid_entry)
  );
`else
  assign in_ready = !w_head_valid || out_ready;

  always_comb begin
    w_head_load  = w_push;
    w_head_clear = w_pop && !w_push;
    w_head_src   = w_capture;
  end
`endif

  distram_read_bypass_entry u_head (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_load  (w_head_load),
    .i_entry (w_head_src),
    .i_clear (w_head_clear),
    .i_hit0  (w_head_hit0),
    .i_hit1  (w_head_hit1),
    .i_wdata (wdata),
    .o_valid (w_head_valid),
    .o_entry (w_head_entry)
  );

  assign out_valid = w_head_valid;
  assign out_data0 = w_head_entry.data0;
  assign out_data1 = w_head_entry.data1;
  assign out_tag   = w_head_entry.tag;

endmodule

// File: tb/tb_distram_read_bypass_stage.sv
// Bench for distram_read_bypass_stage: behavioural array plus an in-order request queue;
// every delivered word must equal the array's current committed contents.
module tb_distram_read_bypass_stage;

  localparam int IW = 32;
  localparam int OW = 32;
  localparam int TW = 8;
  localparam int XW = $clog2(OW);
  localparam int QW = 2 * XW + TW;

  logic          CLK;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_index0;
  logic [XW-1:0] in_index1;
  logic [TW-1:0] in_tag;
  logic [XW-1:0] port0_rindex;
  logic [IW-1:0] port0_rdata;
  logic [XW-1:0] port1_rindex;
  logic [IW-1:0] port1_rdata;
  logic          wen;
  logic [XW-1:0] windex;
  logic [IW-1:0] wdata;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_data0;
  logic [IW-1:0] out_data1;
  logic [TW-1:0] out_tag;

  logic [IW-1:0] mem [OW];
  logic [QW-1:0] exp_q [$];
  int            n_checks;
  int            n_errors;

  distram_read_bypass_stage dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_index0    (in_index0),
    .in_index1    (in_index1),
    .in_tag       (in_tag),
    .port0_rindex (port0_rindex),
    .port0_rdata  (port0_rdata),
    .port1_rindex (port1_rindex),
    .port1_rdata  (port1_rdata),
    .wen          (wen),
    .windex       (windex),
    .wdata        (wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data0    (out_data0),
    .out_data1    (out_data1),
    .out_tag      (out_tag)
  );

  // ---------------- clock / reset / array model ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (wen) mem[windex] <= wdata;
  assign port0_rdata = mem[port0_rindex];
  assign port1_rdata = mem[port1_rindex];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_index0 = '0;
    in_index1 = '0;
    in_tag    = '0;
    wen       = 1'b0;
    windex    = '0;
    wdata     = '0;
    out_ready = 1'b1;
  endtask

  task automatic write_mem(input logic [XW-1:0] idx, input logic [IW-1:0] val);
    wen = 1'b1; windex = idx; wdata = val;
    step();
    wen = 1'b0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < OW; i++) write_mem(XW'(i), $urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data0 !== '0) begin n_errors++; $display("FAIL reset_data0: got %h want 0", out_data0); end
    n_checks++; if (out_data1 !== '0) begin n_errors++; $display("FAIL reset_data1: got %h want 0", out_data1); end
    n_checks++; if (out_tag !== '0) begin n_errors++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_basic_read();
    write_mem(3, 32'hAAAA);
    write_mem(7, 32'h5555);
    out_ready = 1'b1; in_valid = 1'b1; in_index0 = 3; in_index1 = 7; in_tag = 8'h12;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data0 !== 32'hAAAA) begin n_errors++; $display("FAIL basic_data0: got %h want 0000aaaa", out_data0); end
    n_checks++; if (out_data1 !== 32'h5555) begin n_errors++; $display("FAIL basic_data1: got %h want 00005555", out_data1); end
    n_checks++; if (out_tag !== 8'h12) begin n_errors++; $display("FAIL basic_tag: got %h want 12", out_tag); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_forward();
    write_mem(5, 32'h1);
    out_ready = 1'b1; in_valid = 1'b1; in_index0 = 5; in_index1 = 5; in_tag = 8'h21;
    wen = 1'b1; windex = 5; wdata = 32'hBEEF;
    step();
    in_valid = 1'b0; wen = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL fwd_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data0 !== 32'hBEEF) begin n_errors++; $display("FAIL fwd_data0: got %h want 0000beef", out_data0); end
    n_checks++; if (out_data1 !== 32'hBEEF) begin n_errors++; $display("FAIL fwd_data1: got %h want 0000beef", out_data1); end
    step();
  endtask

  task automatic test_stall_snoop();
    write_mem(9, 32'h9999);
    write_mem(2, 32'h2222);
    out_ready = 1'b0; in_valid = 1'b1; in_index0 = 9; in_index1 = 2; in_tag = 8'h33;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_data0 !== 32'h9999) begin n_errors++; $display("FAIL stall_c1_data0: got %h want 00009999", out_data0); end
    wen = 1'b1; windex = 9; wdata = 32'hCAFE;
    #1;
    n_checks++; if (out_data0 !== 32'h9999) begin n_errors++; $display("FAIL stall_c2_data0: got %h want 00009999", out_data0); end
    step();
    wen = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data0 !== 32'hCAFE) begin n_errors++; $display("FAIL stall_snoop_data0: got %h want 0000cafe", out_data0); end
    n_checks++; if (out_data1 !== 32'h2222) begin n_errors++; $display("FAIL stall_data1: got %h want 00002222", out_data1); end
    n_checks++; if (out_tag !== 8'h33) begin n_errors++; $display("FAIL stall_tag: got %h want 33", out_tag); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [XW-1:0] i0;
    logic [XW-1:0] i1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i0 = XW'($urandom_range(0, OW - 1));
      i1 = XW'($urandom_range(0, OW - 1));
      in_valid = 1'b1; in_index0 = i0; in_index1 = i1; in_tag = TW'(k);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); end
      n_checks++; if (out_tag !== TW'(k)) begin n_errors++; $display("FAIL b2b_tag[%0d]: got %h want %h", k, out_tag, TW'(k)); end
      n_checks++; if (out_data0 !== mem[i0] || out_data1 !== mem[i1]) begin
        n_errors++; $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", k, out_data0, out_data1, mem[i0], mem[i1]);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_index0 = 1; in_index1 = 2; in_tag = 8'hA1;
    step();
    in_index0 = 3; in_index1 = 4; in_tag = 8'hB2;
    #1;
`ifdef DISTRAM_READ_BYPASS_SKID_EN
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL skid_first_accept: got %b want 1", in_ready); end
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL skid_full_ready: got %b want 0", in_ready); end
    in_tag = 8'hC3;
    step();
    n_checks++; if (out_tag !== 8'hA1 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL skid_hold: got tag %h ready %b want tag a1 ready 0", out_tag, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 8'hB2 || out_data0 !== mem[3]) begin
      n_errors++; $display("FAIL skid_advance: got v=%b tag=%h d0=%h want v=1 tag=b2 d0=%h", out_valid, out_tag, out_data0, mem[3]);
    end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL skid_ready_back: got %b want 1", in_ready); end
`else
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 8'hA1) begin
      n_errors++; $display("FAIL bp_hold: got v=%b tag=%h want v=1 tag=a1", out_valid, out_tag);
    end
    in_valid = 1'b0; out_ready = 1'b1;
`endif
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_random(input int n_cycles);
    logic          hold;
    logic          push;
    logic          pop;
    logic [QW-1:0] e;
    logic [XW-1:0] e0;
    logic [XW-1:0] e1;
    logic [TW-1:0] et;
    int            budget;
    hold = 1'b0;
    for (int c = 0; c < n_cycles; c++) begin
      if (!hold) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_index0 = XW'($urandom_range(0, OW - 1));
        in_index1 = ($urandom_range(0, 3) == 0) ? in_index0 : XW'($urandom_range(0, OW - 1));
        in_tag    = TW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      wen       = ($urandom_range(0, 1) != 0);
      case ($urandom_range(0, 2))
        0:       windex = in_index0;
        1:       windex = in_index1;
        default: windex = XW'($urandom_range(0, OW - 1));
      endcase
      wdata = $urandom;
      #1;
      push = in_valid && in_ready;
      pop  = out_valid && out_ready;
      if (pop) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL rand_spurious[%0d]: got output tag %h want none", c, out_tag);
        end else begin
          e = exp_q.pop_front();
          e0 = e[QW-1 -: XW]; e1 = e[TW+XW-1 -: XW]; et = e[TW-1:0];
          if (out_tag !== et || out_data0 !== mem[e0] || out_data1 !== mem[e1]) begin
            n_errors++;
            $display("FAIL rand_result[%0d]: got %h/%h/%h want %h/%h/%h", c, out_tag, out_data0, out_data1, et, mem[e0], mem[e1]);
          end
        end
      end
      if (push) exp_q.push_back({in_index0, in_index1, in_tag});
      hold = in_valid && !push;
      step();
      n_checks++; if (out_valid !== (exp_q.size() != 0)) begin
        n_errors++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, exp_q.size() != 0);
      end
    end
    in_valid = 1'b0; wen = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 8) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        e0 = e[QW-1 -: XW]; e1 = e[TW+XW-1 -: XW]; et = e[TW-1:0];
        n_checks++; if (out_tag !== et || out_data0 !== mem[e0] || out_data1 !== mem[e1]) begin
          n_errors++; $display("FAIL drain_result: got %h/%h/%h want %h/%h/%h", out_tag, out_data0, out_data1, et, mem[e0], mem[e1]);
        end
      end
      step();
      budget++;
    end
    n_checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_empty: got %0d pending, valid %b want 0 pending, valid 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_index0 = 1; in_index1 = 2; in_tag = 8'h44;
    step();
`ifdef DISTRAM_READ_BYPASS_SKID_EN
    in_tag = 8'h45;
    step();
`endif
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    #2;
    nRST = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    n_checks++; if (out_tag !== '0 || out_data0 !== '0) begin
      n_errors++; $display("FAIL rst_async_data: got tag %h d0 %h want 0/0", out_tag, out_data0);
    end
    step();
    nRST = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_after_release: got %b want 0", out_valid); end
    test_basic_read();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    init_mem();
    test_basic_read();
    test_forward();
    test_stall_snoop();
    test_back_to_back();
    test_backpressure();
    test_random(400);
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
